// File: rtl/sub_nibble_seq.sv
// Wide subtraction by time-multiplexing one external 4-bit ripple-borrow subtractor.
// Operands are consumed least-significant nibble first, with the borrow chained between nibbles.
module sub_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 borrow_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 borrow_out,
  output logic [3:0]           sub_a,
  output logic [3:0]           sub_b,
  output logic                 sub_bin,
  input  logic [3:0]           sub_y,
  input  logic                 sub_bout
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  // a_q/b_q hold the nibbles not yet presented to the subtractor, shifted down.
  logic [W-1:0]     a_q, b_q;
  logic [W-1:0]     result_q;
  logic             busy_q, done_q, borrow_out_q;
  logic [3:0]       sub_a_q, sub_b_q;
  // sub_bin_q doubles as the chain-borrow register while running.
  logic             sub_bin_q;

  // NOTE: every register here is updated with <= so all state advances from the
  // same pre-edge values; blocking assignments would let later lines see new values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      borrow_out_q <= 1'b0;
      sub_a_q      <= '0;
      sub_b_q      <= '0;
      sub_bin_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q   <= ST_RUN;
            busy_q    <= 1'b1;
            idx_q     <= '0;
            sub_a_q   <= a[3:0];
            sub_b_q   <= b[3:0];
            sub_bin_q <= borrow_in;
            a_q       <= a >> 4;
            b_q       <= b >> 4;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_RUN: begin
          result_q[4*idx_q +: 4] <= sub_y;
          if (idx_q == LAST_IDX) begin
            state_q      <= ST_DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            borrow_out_q <= sub_bout;
            idx_q        <= '0;
            sub_a_q      <= '0;
            sub_b_q      <= '0;
            sub_bin_q    <= 1'b0;
          end else begin
            idx_q     <= idx_q + IDX_W'(1);
            sub_a_q   <= a_q[3:0];
            sub_b_q   <= b_q[3:0];
            sub_bin_q <= sub_bout;
            a_q       <= a_q >> 4;
            b_q       <= b_q >> 4;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign borrow_out = borrow_out_q;
  assign sub_a      = sub_a_q;
  assign sub_b      = sub_b_q;
  assign sub_bin    = sub_bin_q;

endmodule

// File: tb/tb_sub_nibble_seq.sv
// Bench for sub_nibble_seq: a 4-nibble and a 1-nibble instance, each wired to a
// combinational 4-bit subtractor, checked against an arithmetic model and literal vectors.
module tb_sub_nibble_seq;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-nibble instance
  logic         start, borrow_in, busy, done, borrow_out, sub_bin, sub_bout;
  logic [W-1:0] a, b, result;
  logic [3:0]   sub_a, sub_b, sub_y;
  logic [4:0]   diff4;

  assign diff4    = {1'b0, sub_a} - {1'b0, sub_b} - {4'b0, sub_bin};
  assign sub_y    = diff4[3:0];
  assign sub_bout = diff4[4];

  sub_nibble_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
    .busy(busy), .done(done), .result(result), .borrow_out(borrow_out),
    .sub_a(sub_a), .sub_b(sub_b), .sub_bin(sub_bin),
    .sub_y(sub_y), .sub_bout(sub_bout)
  );

  // 1-nibble instance
  logic       start1, bin1, busy1, done1, bout1, sub_bin1, sub_bout1;
  logic [3:0] a1, b1, result1, sub_a1, sub_b1, sub_y1;
  logic [4:0] diff1;

  assign diff1     = {1'b0, sub_a1} - {1'b0, sub_b1} - {4'b0, sub_bin1};
  assign sub_y1    = diff1[3:0];
  assign sub_bout1 = diff1[4];

  sub_nibble_seq #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .borrow_in(bin1),
    .busy(busy1), .done(done1), .result(result1), .borrow_out(bout1),
    .sub_a(sub_a1), .sub_b(sub_b1), .sub_bin(sub_bin1),
    .sub_y(sub_y1), .sub_bout(sub_bout1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the 4-nibble instance: m_cnt = 0 idle, 1..N running nibble m_cnt-1, N+1 done.
  int unsigned m_cnt, m_a, m_b, m_bin, m_res, m_bo;
  logic        m_run;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_a = 0; m_b = 0; m_bin = 0; m_res = 0; m_bo = 0;
    end else if (m_cnt == 0 || m_cnt == N + 1) begin
      if (start) begin
        m_a = a; m_b = b; m_bin = borrow_in; m_cnt = 1;
      end else begin
        m_cnt = 0;
      end
    end else if (m_cnt < N) begin
      m_cnt++;
    end else begin
      m_cnt = N + 1;
      m_res = (m_a - m_b - m_bin) & 32'hFFFF;
      m_bo  = (m_a < m_b + m_bin) ? 1 : 0;
    end
  end

  assign m_run = (m_cnt >= 1) && (m_cnt <= N);

  // Borrow into nibble k is whether the low 4k bits of A fall short of B plus borrow_in.
  function automatic int unsigned exp_bin(input int unsigned k);
    int unsigned mask;
    mask = (k == 0) ? 0 : ((32'h1 << (4 * k)) - 1);
    return ((m_a & mask) < ((m_b & mask) + m_bin)) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", busy, m_run);
      check("done", done, m_cnt == N + 1);
      check("sub_a", sub_a, m_run ? ((m_a >> (4 * (m_cnt - 1))) & 15) : 0);
      check("sub_b", sub_b, m_run ? ((m_b >> (4 * (m_cnt - 1))) & 15) : 0);
      check("sub_bin", sub_bin, m_run ? exp_bin(m_cnt - 1) : 0);
      if (!m_run) begin
        check("result", result, m_res);
        check("borrow_out", borrow_out, m_bo);
      end
    end
  end

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic bin,
                        output logic [15:0] sa, output logic [15:0] sb,
                        output logic [3:0] sbin, output int nbusy, output bit got);
    @(posedge clk); #2;
    start = 1'b1; a = av; b = bv; borrow_in = bin;
    @(posedge clk); #2;
    start = 1'b0;
    sa = '0; sb = '0; sbin = '0; nbusy = 0; got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
      end else if (busy) begin
        nbusy++;
        sa   = {sa[11:0], sub_a};
        sb   = {sb[11:0], sub_b};
        sbin = {sbin[2:0], sub_bin};
      end
    end
  endtask

  task automatic wait_done(input string nm);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check(nm, got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] sa, sb;
    logic [3:0]  sbin;
    int          nb, ndone;
    bit          got;

    start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_sub_a", sub_a, 0);
    @(negedge clk); rst = 1'b0;

    // Plain subtraction, no borrows.
    run_op(16'h1234, 16'h0234, 1'b0, sa, sb, sbin, nb, got);
    check("t1_done_seen", got, 1);
    check("t1_busy_cycles", nb, 4);
    check("t1_sub_a_seq", sa, 16'h4321);
    check("t1_sub_b_seq", sb, 16'h4320);
    check("t1_result", result, 16'h1000);
    check("t1_borrow_out", borrow_out, 0);

    // Underflow wraps and the borrow ripples to the top.
    run_op(16'h0000, 16'h0001, 1'b0, sa, sb, sbin, nb, got);
    check("t2_done_seen", got, 1);
    check("t2_sub_bin_seq", sbin, 4'b0111);
    check("t2_result", result, 16'hFFFF);
    check("t2_borrow_out", borrow_out, 1);

    run_op(16'h1000, 16'h0001, 1'b0, sa, sb, sbin, nb, got);
    check("t3_result", result, 16'h0FFF);
    check("t3_borrow_out", borrow_out, 0);

    run_op(16'h0005, 16'h0003, 1'b1, sa, sb, sbin, nb, got);
    check("t3b_result", result, 16'h0001);
    check("t3b_borrow_out", borrow_out, 0);

    // Start during RUN is ignored; start in DONE is accepted back-to-back.
    @(posedge clk); #2;
    start = 1'b1; a = 16'h00FF; b = 16'h000F; borrow_in = 1'b0;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    start = 1'b1; a = 16'hAAAA;
    @(posedge clk); #2;
    start = 1'b0; a = '0;
    repeat (2) @(posedge clk);
    #2;
    check("t4_done", done, 1);
    check("t4_result", result, 16'h00F0);
    check("t4_borrow_out", borrow_out, 0);
    start = 1'b1; a = 16'h0010; b = 16'h0020;
    @(posedge clk); #2;
    start = 1'b0;
    check("t4_b2b_busy", busy, 1);
    wait_done("t4_b2b_done_seen");
    check("t4_b2b_result", result, 16'hFFF0);
    check("t4_b2b_borrow_out", borrow_out, 1);

    // Asynchronous reset in the middle of nibble 2.
    @(posedge clk); #2;
    start = 1'b1; a = 16'h5555; b = 16'h1111;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("t5_pre_sub_a", sub_a, 5);
    #1 rst = 1'b1;
    #1;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_result", result, 0);
    check("t5_borrow_out", borrow_out, 0);
    check("t5_sub_a", sub_a, 0);
    check("t5_sub_b", sub_b, 0);
    check("t5_sub_bin", sub_bin, 0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("t5_no_done_after_abort", ndone, 0);
    run_op(16'h0003, 16'h0001, 1'b0, sa, sb, sbin, nb, got);
    check("t5_after_done_seen", got, 1);
    check("t5_after_result", result, 16'h0002);

    // Single-nibble instance.
    @(posedge clk); #2;
    start1 = 1'b1; a1 = 4'h3; b1 = 4'h5; bin1 = 1'b0;
    @(posedge clk); #2;
    start1 = 1'b0;
    check("n1_busy", busy1, 1);
    check("n1_done_early", done1, 0);
    check("n1_sub_a", sub_a1, 3);
    check("n1_sub_b", sub_b1, 5);
    @(posedge clk); #2;
    check("n1_busy_off", busy1, 0);
    check("n1_done", done1, 1);
    check("n1_result", result1, 4'hE);
    check("n1_borrow_out", bout1, 1);
    @(posedge clk); #2;
    check("n1_done_pulse", done1, 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sub_nibble_seq.md
Name: sub_nibble_seq

Overview:
Sequencer that performs a wide (4*NIBBLES-bit) subtraction by time-multiplexing one external 4-bit ripple-borrow subtractor, least-significant nibble first. It captures both operands on a start handshake and drives the subtractor's A/B/borrow-in inputs one nibble per clock. It chains the borrow between nibbles and assembles the result. It sits between the button/operand-entry logic and the shared 4-bit subtractor on the Gowin board design.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand (operand width W = 4*NIBBLES); legal range 1..8.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a subtraction; sampled on rising clk
a  input  W  minuend; sampled with start
b  input  W  subtrahend; sampled with start
borrow_in  input  1  initial borrow into nibble 0; sampled with start
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse when result/borrow_out become valid
result  output  W  A - B - borrow_in, modulo 2^W; held until the next accepted start
borrow_out  output  1  final borrow (1 = A < B + borrow_in); held with result
sub_a  output  4  to subtractor A: current minuend nibble
sub_b  output  4  to subtractor B: current subtrahend nibble
sub_bin  output  1  to subtractor BorrowIN: chained borrow
sub_y  input  4  from subtractor difference (combinational)
sub_bout  input  1  from subtractor BorrowOUT (combinational)

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, result=0, borrow_out=0, sub_a=0, sub_b=0, sub_bin=0; nibble index=0; operand registers=0.
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. If start=1 at an edge, register a, b, and borrow_in into the chain-borrow register; set index=0; go to RUN. Otherwise stay.
- RUN: busy=1. sub_a = a_reg[4*idx+3:4*idx], sub_b = b_reg nibble idx, sub_bin = chain-borrow register. All three are registered/muxed so they are stable for the whole cycle.
- RUN, on each edge: result nibble idx <= sub_y; chain-borrow <= sub_bout; idx <= idx+1. After the edge capturing idx=NIBBLES-1: borrow_out <= sub_bout; go to DONE.
- Result nibbles update progressively during RUN. Consumers use result only when done=1 or when idle after done.
- DONE: busy=0, done=1 for exactly one cycle; result/borrow_out valid. Next state is IDLE. A start in DONE is accepted exactly as in IDLE (back-to-back operation), going to RUN.
- Latency: start sampled at edge E0 -> busy high cycles E0..E0+NIBBLES -> done high in cycle after edge E0+NIBBLES. Throughput: one op per NIBBLES+1 cycles.
- start while in RUN: ignored. Operands are not re-sampled and there is no queuing.
- Outside RUN: sub_a, sub_b, and sub_bin are driven to 0.
- Width rule: result is W-bit modulo arithmetic. borrow_out is the only sign/overflow indication, with no separate negative flag.
- Reset mid-RUN: immediate abort. All outputs return to reset values and no done pulse is issued.
- The external subtractor is purely combinational. The sequencer assumes sub_y/sub_bout settle within one clock period.
- NIBBLES=1: RUN lasts a single cycle. Behaviour is otherwise identical.

Test Plan:
- NIBBLES=4; a=0x1234, b=0x0234, borrow_in=0, start one cycle -> busy high 4 cycles. sub_a sequence is 4,3,2,1 and sub_b sequence is 4,3,2,0. done pulses once; result=0x1000, borrow_out=0.
- a=0x0000, b=0x0001, borrow_in=0 -> sub_bin sequence is 0,1,1,1; result=0xFFFF, borrow_out=1.
- a=0x1000, b=0x0001 (borrow ripples across three nibbles) -> result=0x0FFF, borrow_out=0. Separately, a=0x0005, b=0x0003, borrow_in=1 -> result=0x0001, borrow_out=0.
- Start a=0x00FF, b=0x000F. During cycle 2 of RUN pulse start with a=0xAAAA -> ignored; result=0x00F0. Then assert start in the DONE cycle with a=0x0010, b=0x0020 -> accepted without an idle cycle; result=0xFFF0, borrow_out=1.
- Assert rst asynchronously (mid-cycle) during RUN nibble 2 -> busy, done, result, and sub_* go to 0 immediately, and no done pulse follows. After release, a new start with 0x0003-0x0001 gives 0x0002.
- NIBBLES=1 build: a=0x3, b=0x5 -> busy 1 cycle, done next cycle, result=0xE, borrow_out=1.
